// File: rtl/uart_tx_arbiter_if.sv
// Requester/UART-side bundle for uart_tx_arbiter: master = clients + uart_tx, slave = arbiter.
// Requesters hold req/req_data until ack; the arbiter owns tx_start/tx_data until tx_done_tick.
interface uart_tx_arbiter_if #(
  parameter int NREQ = 4,
  parameter int DBIT = 8
);
  localparam int IW = $clog2(NREQ);

  logic [NREQ-1:0]      req;
  logic [NREQ*DBIT-1:0] req_data;
  logic [NREQ-1:0]      ack;
  logic [NREQ-1:0]      done;
  logic                 tx_start;
  logic [DBIT-1:0]      tx_data;
  logic                 tx_done_tick;
  logic                 busy;
  logic [IW-1:0]        owner;
  logic                 timeout_err;

  modport master (
    output req, req_data, tx_done_tick,
    input  ack, done, tx_start, tx_data, busy, owner, timeout_err
  );

  modport slave (
    input  req, req_data, tx_done_tick,
    output ack, done, tx_start, tx_data, busy, owner, timeout_err
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharer of one uart_tx: ack/tx_start 1 cycle after req is sampled, done 1 cycle after tx_done_tick.
// Frame ownership holds off all other requesters; optional frame watchdog under UART_TX_ARBITER_TIMEOUT_EN.
module uart_tx_arbiter #(
  parameter int NREQ           = 4,
  parameter int DBIT           = 8,
  parameter int TIMEOUT_CYCLES = 131072
) (
  input  logic            clk,
  input  logic            rst,
  uart_tx_arbiter_if.slave bus
);
  localparam int IW = $clog2(NREQ);

  if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
    $error("uart_tx_arbiter: NREQ must be in 2..8");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("uart_tx_arbiter: TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic [NREQ-1:0] done_q, done_d;
  logic [DBIT-1:0] tx_data_q, tx_data_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [IW-1:0]   last_q, last_d;

  logic [IW-1:0]   win;
  logic            win_vld;
  logic [DBIT-1:0] win_data;
  logic [IW:0]     sum;
  logic [IW-1:0]   cand;
  logic            expire;

`ifdef UART_TX_ARBITER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          to_err_q, to_err_d;

  // Terminal cycle is the TIMEOUT_CYCLES-th WAIT cycle; a same-cycle tx_done_tick wins.
  always_comb begin
    expire   = (state_q == WAIT) && !bus.tx_done_tick && (cnt_q == CW'(TIMEOUT_CYCLES - 1));
    cnt_d    = (state_q == WAIT) ? cnt_q + 1'b1 : '0;
    to_err_d = to_err_q | expire;
  end
`else
  assign expire = 1'b0;
`endif

  // Search starts just after the last completed owner, wrapping modulo NREQ.
  always_comb begin
    win      = '0;
    win_vld  = 1'b0;
    sum      = '0;
    cand     = '0;
    win_data = '0;
    for (int k = 1; k <= NREQ; k++) begin
      sum = {1'b0, last_q} + (IW+1)'(k);
      if (sum >= (IW+1)'(NREQ)) begin
        sum = sum - (IW+1)'(NREQ);
      end
      cand = sum[IW-1:0];
      if (!win_vld && bus.req[cand]) begin
        win     = cand;
        win_vld = 1'b1;
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (IW'(i) == win) begin
        win_data = bus.req_data[i*DBIT +: DBIT];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ack_d     = '0;
    done_d    = '0;
    tx_data_d = tx_data_q;
    owner_d   = owner_q;
    last_d    = last_q;
    case (state_q)
      IDLE: begin
        if (win_vld) begin
          tx_data_d = win_data;
          owner_d   = win;
          ack_d     = NREQ'(1) << win;
          state_d   = START;
        end
      end
      START: state_d = WAIT;
      WAIT: begin
        if (bus.tx_done_tick || expire) begin
          done_d  = NREQ'(1) << owner_q;
          last_d  = owner_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      ack_q     <= '0;
      done_q    <= '0;
      tx_data_q <= '0;
      owner_q   <= '0;
      last_q    <= IW'(NREQ - 1);
`ifdef UART_TX_ARBITER_TIMEOUT_EN
      cnt_q     <= '0;
      to_err_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      ack_q     <= ack_d;
      done_q    <= done_d;
      tx_data_q <= tx_data_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
`ifdef UART_TX_ARBITER_TIMEOUT_EN
      cnt_q     <= cnt_d;
      to_err_q  <= to_err_d;
`endif
    end
  end

  assign bus.ack      = ack_q;
  assign bus.done     = done_q;
  assign bus.tx_start = (state_q == START);
  assign bus.tx_data  = tx_data_q;
  assign bus.busy     = (state_q == START) || (state_q == WAIT);
  assign bus.owner    = owner_q;
`ifdef UART_TX_ARBITER_TIMEOUT_EN
  assign bus.timeout_err = to_err_q;
`else
  assign bus.timeout_err = 1'b0;
`endif

  a_ack_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(bus.ack));
  a_done_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(bus.done));
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: vector table plus hand-written multi-cycle sequences.
module tb_uart_tx_arbiter;
  localparam int NREQ = 4;
  localparam int DBIT = 8;
`ifdef UART_TX_ARBITER_TIMEOUT_EN
  localparam int DLY_A = 12;
`else
  localparam int DLY_A = 20;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  int nstart = 0;
  int ndone = 0;
  int nack1 = 0;

  uart_tx_arbiter_if #(.NREQ(NREQ), .DBIT(DBIT)) bus ();

  uart_tx_arbiter #(.NREQ(NREQ), .DBIT(DBIT), .TIMEOUT_CYCLES(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  req;
    logic [31:0] data;
    logic        tick;
    logic [3:0]  ack;
    logic [3:0]  done;
    logic        start;
    logic        busy;
    logic [1:0]  owner;
    logic [7:0]  txd;
  } vec_t;

  vec_t tbl [12];

  function automatic logic [3:0] onehot(input int i);
    logic [3:0] one;
    one = 4'b0001;
    return one << i;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (bus.tx_start) nstart++;
    if (bus.done != 4'b0000) ndone++;
    if (bus.ack[1]) nack1++;
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_ack"}, 32'(bus.ack), 32'd0);
    chk({nm, "_done"}, 32'(bus.done), 32'd0);
    chk({nm, "_start"}, 32'(bus.tx_start), 32'd0);
    chk({nm, "_txd"}, 32'(bus.tx_data), 32'd0);
    chk({nm, "_busy"}, 32'(bus.busy), 32'd0);
    chk({nm, "_owner"}, 32'(bus.owner), 32'd0);
    chk({nm, "_terr"}, 32'(bus.timeout_err), 32'd0);
  endtask

  // Waits for a grant, checks it, then completes the frame dly cycles after tx_start.
  task automatic do_frame(input int own, input logic [7:0] b, input int dly, input bit drop);
    int n;
    n = 0;
    while (!bus.tx_start && n < 8) begin
      step();
      n++;
    end
    chk("frame_start", 32'(bus.tx_start), 32'd1);
    chk("frame_owner", 32'(bus.owner), 32'(own));
    chk("frame_ack", 32'(bus.ack), 32'(onehot(own)));
    chk("frame_data", 32'(bus.tx_data), 32'(b));
    if (drop) bus.req[own] = 1'b0;
    repeat (dly) step();
    bus.tx_done_tick = 1'b1;
    step();
    bus.tx_done_tick = 1'b0;
    chk("frame_done", 32'(bus.done), 32'(onehot(own)));
    chk("frame_busy", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    int s;
    //                req      data          tick  ack      done     st    busy  own   txd
    tbl[0]  = '{4'b0001, 32'h000000A5, 1'b0, 4'b0001, 4'b0000, 1'b1, 1'b1, 2'd0, 8'hA5};
    tbl[1]  = '{4'b0000, 32'h000000A5, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 2'd0, 8'hA5};
    tbl[2]  = '{4'b0000, 32'h000000A5, 1'b1, 4'b0000, 4'b0001, 1'b0, 1'b0, 2'd0, 8'hA5};
    tbl[3]  = '{4'b0000, 32'h000000A5, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0, 8'hA5};
    tbl[4]  = '{4'b1010, 32'h33001100, 1'b0, 4'b0010, 4'b0000, 1'b1, 1'b1, 2'd1, 8'h11};
    tbl[5]  = '{4'b1010, 32'h33001100, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b1, 2'd1, 8'h11};
    tbl[6]  = '{4'b1010, 32'h33001100, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 2'd1, 8'h11};
    tbl[7]  = '{4'b1000, 32'h33001100, 1'b1, 4'b0000, 4'b0010, 1'b0, 1'b0, 2'd1, 8'h11};
    tbl[8]  = '{4'b1000, 32'h33001100, 1'b0, 4'b1000, 4'b0000, 1'b1, 1'b1, 2'd3, 8'h33};
    tbl[9]  = '{4'b0000, 32'h33001100, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 2'd3, 8'h33};
    tbl[10] = '{4'b0000, 32'h33001100, 1'b1, 4'b0000, 4'b1000, 1'b0, 1'b0, 2'd3, 8'h33};
    tbl[11] = '{4'b0000, 32'h33001100, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd3, 8'h33};

    bus.req = '0;
    bus.req_data = '0;
    bus.tx_done_tick = 1'b0;

    // Reset state
    step();
    step();
    chk_all_zero("reset");
    rst = 1'b0;

    // Vector table: one edge per record
    for (int i = 0; i < 12; i++) begin
      bus.req = tbl[i].req;
      bus.req_data = tbl[i].data;
      bus.tx_done_tick = tbl[i].tick;
      step();
      chk($sformatf("row%0d_ack", i), 32'(bus.ack), 32'(tbl[i].ack));
      chk($sformatf("row%0d_done", i), 32'(bus.done), 32'(tbl[i].done));
      chk($sformatf("row%0d_start", i), 32'(bus.tx_start), 32'(tbl[i].start));
      chk($sformatf("row%0d_busy", i), 32'(bus.busy), 32'(tbl[i].busy));
      chk($sformatf("row%0d_owner", i), 32'(bus.owner), 32'(tbl[i].owner));
      chk($sformatf("row%0d_txd", i), 32'(bus.tx_data), 32'(tbl[i].txd));
      chk($sformatf("row%0d_terr", i), 32'(bus.timeout_err), 32'd0);
    end
    bus.tx_done_tick = 1'b0;

    // Single frame with a long uart_tx time
    bus.req = 4'b0001;
    bus.req_data = 32'h000000A5;
    step();
    chk("a_ack", 32'(bus.ack), 32'h1);
    chk("a_start", 32'(bus.tx_start), 32'd1);
    chk("a_txd", 32'(bus.tx_data), 32'hA5);
    bus.req = 4'b0000;
    s = ndone;
    repeat (DLY_A) step();
    chk("a_no_early_done", 32'(ndone - s), 32'd0);
    chk("a_busy_wait", 32'(bus.busy), 32'd1);
    bus.tx_done_tick = 1'b1;
    step();
    bus.tx_done_tick = 1'b0;
    chk("a_done", 32'(bus.done), 32'h1);
    chk("a_busy_after", 32'(bus.busy), 32'd0);

    // Fresh reset, then all four requesting: order 0,1,2,3,0
    rst = 1'b1;
    step();
    chk_all_zero("rst2");
    rst = 1'b0;
    bus.req = 4'b1111;
    bus.req_data = 32'h44332211;
    s = nstart;
    for (int f = 0; f < 5; f++) begin
      do_frame(f % 4, 8'(8'h11 * ((f % 4) + 1)), 10, 1'b0);
    end
    chk("b_start_count", 32'(nstart - s), 32'd5);

    // Requester 2 alone, then 0 and 2 compete while last=2
    bus.req = 4'b0100;
    bus.req_data = 32'h00C20000;
    do_frame(2, 8'hC2, 4, 1'b0);
    step();
    chk("c_regrant_start", 32'(bus.tx_start), 32'd1);
    chk("c_regrant_owner", 32'(bus.owner), 32'd2);
    step();
    bus.req = 4'b0101;
    bus.req_data = 32'h00C2000C;
    repeat (2) step();
    bus.tx_done_tick = 1'b1;
    step();
    bus.tx_done_tick = 1'b0;
    chk("c_regrant_done", 32'(bus.done), 32'h4);
    do_frame(0, 8'h0C, 4, 1'b1);
    do_frame(2, 8'hC2, 4, 1'b1);

    // Requester 1 pulses req for one WAIT cycle only: withdrawn
    bus.req = 4'b1000;
    bus.req_data = 32'hD3000000;
    step();
    chk("d_start", 32'(bus.tx_start), 32'd1);
    chk("d_owner", 32'(bus.owner), 32'd3);
    bus.req = 4'b0000;
    step();
    s = nack1;
    bus.req = 4'b0010;
    bus.req_data = 32'h0000D100;
    step();
    bus.req = 4'b0000;
    step();
    bus.tx_done_tick = 1'b1;
    step();
    bus.tx_done_tick = 1'b0;
    chk("d_done", 32'(bus.done), 32'h8);
    begin
      int s2;
      s2 = nstart;
      repeat (6) step();
      chk("d_no_start", 32'(nstart - s2), 32'd0);
    end
    chk("d_no_ack1", 32'(nack1 - s), 32'd0);

    // Spurious tx_done_tick in IDLE
    s = ndone;
    bus.tx_done_tick = 1'b1;
    step();
    bus.tx_done_tick = 1'b0;
    step();
    chk("e_spurious_done", 32'(ndone - s), 32'd0);
    chk("e_spurious_busy", 32'(bus.busy), 32'd0);

    // last=0, owner 2 in WAIT, then async reset mid-frame
    bus.req = 4'b0001;
    bus.req_data = 32'h00E200E0;
    do_frame(0, 8'hE0, 3, 1'b0);
    bus.req = 4'b0100;
    step();
    chk("e_grant2_owner", 32'(bus.owner), 32'd2);
    bus.req = 4'b0000;
    step();
    step();
    s = ndone;
    #2;
    rst = 1'b1;
    #1;
    chk_all_zero("e_async_rst");
    step();
    step();
    chk("e_rst_no_done", 32'(ndone - s), 32'd0);
    rst = 1'b0;
    bus.req = 4'b1111;
    bus.req_data = 32'h44332211;
    step();
    chk("e_post_rst_owner", 32'(bus.owner), 32'd0);
    chk("e_post_rst_ack", 32'(bus.ack), 32'h1);
    chk("e_post_rst_txd", 32'(bus.tx_data), 32'h11);
    bus.req = 4'b0000;

`ifdef UART_TX_ARBITER_TIMEOUT_EN
    // No tx_done_tick: watchdog completes the frame 17 cycles after tx_start
    s = ndone;
    repeat (16) step();
    chk("f_no_early_done", 32'(ndone - s), 32'd0);
    chk("f_terr_before", 32'(bus.timeout_err), 32'd0);
    step();
    chk("f_timeout_done", 32'(bus.done), 32'h1);
    chk("f_terr_set", 32'(bus.timeout_err), 32'd1);
    chk("f_busy_after", 32'(bus.busy), 32'd0);
    repeat (3) step();
    chk("f_terr_sticky", 32'(bus.timeout_err), 32'd1);
    rst = 1'b1;
    step();
    chk("f_terr_rst", 32'(bus.timeout_err), 32'd0);
    rst = 1'b0;
`else
    // No watchdog: WAIT holds indefinitely
    s = ndone;
    repeat (40) step();
    chk("f_wait_forever_busy", 32'(bus.busy), 32'd1);
    chk("f_wait_forever_done", 32'(ndone - s), 32'd0);
    chk("f_terr_zero", 32'(bus.timeout_err), 32'd0);
    bus.tx_done_tick = 1'b1;
    step();
    bus.tx_done_tick = 1'b0;
    chk("f_late_done", 32'(bus.done), 32'h1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
